// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one free-running random byte among NUM_REQ requesters,
// each result reduced to [0, bound] by mask-and-reject sampling with a bounded-retry fallback.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   rnd_in   : raw random byte, new value each cycle
//   req      : level request per requester, held until ack
//   bound    : inclusive upper limit per requester, slice i = bound[8*i+7:8*i]
//   ack      : one-hot, one-cycle done pulse
//   rnd_out  : bounded result, valid with ack and held until the next ack
//   grant_id : index of the requester being served
//   busy     : high while drawing or acknowledging
module rng_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_TRIES = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 rnd_in,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       bound,
   output logic [NUM_REQ-1:0]         ack,
   output logic [7:0]                 rnd_out,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, sel, idx;
   logic sel_ok;
   logic [7:0] bound_q, bound_d, mask_q, mask_d, rnd_q, rnd_d, sel_bound, sel_mask, cand;
   logic [3:0] tries_q, tries_d;
   // Scan from farthest to nearest after the pointer so the nearest requester wins.
   always_comb begin
      sel = '0;
      sel_ok = 1'b0;
      idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = IW'((int'(ptr_q) + i) % NUM_REQ);
         if (req[idx]) begin
            sel = idx;
            sel_ok = 1'b1;
         end
      end
   end
   assign sel_bound = bound[8*sel +: 8];
   // Smear the top set bit downward: smallest 2^k-1 covering the bound.
   assign sel_mask = sel_bound | (sel_bound >> 1) | (sel_bound >> 2) | (sel_bound >> 3)
                   | (sel_bound >> 4) | (sel_bound >> 5) | (sel_bound >> 6) | (sel_bound >> 7);
   assign cand = rnd_in & mask_q;
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      grant_d = grant_q;
      bound_d = bound_q;
      mask_d = mask_q;
      rnd_d = rnd_q;
      tries_d = tries_q;
      case (state_q)
         IDLE: begin
            if (sel_ok) begin
               state_d = DRAW;
               grant_d = sel;
               bound_d = sel_bound;
               mask_d = sel_mask;
               tries_d = '0;
            end
         end
         DRAW: begin
            if (!req[grant_q]) begin
               state_d = IDLE;
            end else if (cand <= bound_q || tries_q == TRY_LAST) begin
               // Fallback folds the rejected candidate back into range: cand <= 2*bound+1.
               rnd_d = (cand <= bound_q) ? cand : cand - (bound_q + 8'd1);
               ptr_d = grant_q;
               state_d = DONE;
            end else begin
               tries_d = tries_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q <= IW'(NUM_REQ - 1);
         grant_q <= '0;
         bound_q <= '0;
         mask_q <= '0;
         rnd_q <= '0;
         tries_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         grant_q <= grant_d;
         bound_q <= bound_d;
         mask_q <= mask_d;
         rnd_q <= rnd_d;
         tries_q <= tries_d;
      end
   end
   // Decoded from the registered state so an asynchronous reset drops ack at once.
   assign ack = (state_q == DONE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign rnd_out = rnd_q;
   assign grant_id = grant_q;
   assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: vector table plus corner-case sequences, results checked through an expectation queue.
module tb_rng_arbiter;
   localparam int N = 4;
   localparam int MT = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] rnd_in = '0;
   logic [N-1:0] req = '0;
   logic [8*N-1:0] bound = '0;
   logic [N-1:0] ack;
   logic [7:0] rnd_out;
   logic [1:0] grant_id;
   logic busy;
   int n_checks = 0;
   int n_fail = 0;
   typedef struct {
      logic [1:0] id;
      logic [7:0] bnd;
      logic [31:0] rnd;
      logic [7:0] exp_out;
      int draws;
   } vec_t;
   typedef struct {
      logic [1:0] id;
      logic [7:0] out;
   } exp_t;
   exp_t exp_q[$];
   vec_t vecs[10];
   logic [N-1:0] prev_ack = '0;
   rng_arbiter #(.NUM_REQ(N), .MAX_TRIES(MT)) dut (
      .clk(clk), .reset(reset), .rnd_in(rnd_in), .req(req), .bound(bound),
      .ack(ack), .rnd_out(rnd_out), .grant_id(grant_id), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (reset) begin
         prev_ack = '0;
      end else begin
         if (ack != '0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ack: got ack %b expected none at %0t", ack, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ack_onehot", 32'(ack), 32'(1) << e.id);
               check("grant_id", 32'(grant_id), 32'(e.id));
               check("rnd_out", 32'(rnd_out), 32'(e.out));
            end
            check("ack_back_to_back", 32'(prev_ack), 32'd0);
         end
         prev_ack = ack;
      end
   end
   task automatic wait_ack(input int lim);
      int cyc;
      cyc = 0;
      while (ack == '0 && cyc < lim) begin
         @(negedge clk);
         cyc++;
      end
      if (ack == '0) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack expected ack within %0d cycles", lim);
      end
   endtask
   task automatic run_vec(input vec_t v);
      int cyc;
      bit got;
      @(negedge clk);
      req = '0;
      req[v.id] = 1'b1;
      bound[8*v.id +: 8] = v.bnd;
      rnd_in = 8'h5A;
      exp_q.push_back('{v.id, v.exp_out});
      @(negedge clk);
      check("busy_draw", 32'(busy), 32'd1);
      bound[8*v.id +: 8] = ~v.bnd;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 12) begin
         rnd_in = v.rnd[8*(cyc%4) +: 8];
         cyc++;
         @(negedge clk);
         got = (ack != '0);
      end
      check("latency", 32'(cyc), 32'(v.draws));
      req = '0;
      @(negedge clk);
      check("idle_after_done", 32'(busy), 32'd0);
      check("ack_single_cycle", 32'(ack), 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      int cnt;
      int cyc;
      int pending;
      vecs[0] = '{2'd0, 8'd5,   32'h00000003, 8'd3,   1};
      vecs[1] = '{2'd1, 8'd5,   32'h0002070E, 8'd2,   3};
      vecs[2] = '{2'd2, 8'd5,   32'hFFFFFFFF, 8'd1,   4};
      vecs[3] = '{2'd3, 8'd0,   32'h000000AB, 8'd0,   1};
      vecs[4] = '{2'd0, 8'd255, 32'h000000C8, 8'd200, 1};
      vecs[5] = '{2'd1, 8'd100, 32'h006465FF, 8'd100, 3};
      vecs[6] = '{2'd2, 8'd9,   32'h0E0A0C0F, 8'd4,   4};
      vecs[7] = '{2'd3, 8'd128, 32'h00008081, 8'd128, 2};
      vecs[8] = '{2'd0, 8'd1,   32'h000000FE, 8'd0,   1};
      vecs[9] = '{2'd1, 8'd6,   32'h00060F07, 8'd6,   3};
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_rnd_out", 32'(rnd_out), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      @(negedge clk);
      req = 4'b0001;
      bound[7:0] = 8'd5;
      rnd_in = 8'hFF;
      @(negedge clk);
      check("abort_busy_e0", 32'(busy), 32'd1);
      @(negedge clk);
      check("abort_busy_e1", 32'(busy), 32'd1);
      req = '0;
      @(negedge clk);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_rnd_held", 32'(rnd_out), 32'd6);
      repeat (3) @(negedge clk);
      check("abort_no_ack", 32'(ack), 32'd0);
      req = 4'b0011;
      bound[15:0] = {8'd5, 8'd5};
      rnd_in = 8'h03;
      exp_q.push_back('{2'd0, 8'd3});
      @(negedge clk);
      wait_ack(10);
      req = '0;
      @(negedge clk);
      req = 4'b0100;
      bound[23:16] = 8'd5;
      rnd_in = 8'h03;
      exp_q.push_back('{2'd2, 8'd3});
      @(negedge clk);
      wait_ack(10);
      #1 reset = 1'b1;
      #1;
      check("rst_done_ack", 32'(ack), 32'd0);
      check("rst_done_busy", 32'(busy), 32'd0);
      check("rst_done_grant", 32'(grant_id), 32'd0);
      check("rst_done_rnd", 32'(rnd_out), 32'd0);
      req = '0;
      @(negedge clk);
      reset = 1'b0;
      bound = {4{8'd3}};
      rnd_in = 8'h02;
      req = 4'b1111;
      exp_q.push_back('{2'd0, 8'd2});
      exp_q.push_back('{2'd1, 8'd2});
      exp_q.push_back('{2'd2, 8'd2});
      exp_q.push_back('{2'd3, 8'd2});
      exp_q.push_back('{2'd0, 8'd2});
      exp_q.push_back('{2'd1, 8'd2});
      cnt = 0;
      cyc = 0;
      pending = -1;
      while (cnt < 6 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (pending >= 0) begin
            req[pending] = 1'b1;
            pending = -1;
         end
         if (ack != '0) begin
            req[grant_id] = 1'b0;
            cnt++;
            if (cnt < 5) pending = int'(grant_id);
         end
      end
      req = '0;
      check("rr_grant_count", 32'(cnt), 32'd6);
      repeat (4) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_idle", 32'(busy), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
